// File: rtl/branch_resolver_if.sv
// rtl/branch_resolver_if.sv - prediction, resolve and training/redirect channels of the branch resolver
interface branch_resolver_if #(
    parameter int PC_W = 32
);
    logic            pred_valid;
    logic            pred_taken;
    logic [PC_W-1:0] pred_fallthrough;
    logic            pred_ready;
    logic            resolve_valid;
    logic            resolve_taken;
    logic [PC_W-1:0] resolve_target;
    logic            upd_branch;
    logic            upd_taken;
    logic            flush;
    logic [PC_W-1:0] redirect_pc;

    // Pipeline side: fetch pushes predictions, execute resolves them
    modport master (
        output pred_valid, pred_taken, pred_fallthrough,
        output resolve_valid, resolve_taken, resolve_target,
        input  pred_ready, upd_branch, upd_taken, flush, redirect_pc
    );

    // Resolver side
    modport slave (
        input  pred_valid, pred_taken, pred_fallthrough,
        input  resolve_valid, resolve_taken, resolve_target,
        output pred_ready, upd_branch, upd_taken, flush, redirect_pc
    );
endinterface

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-order prediction queue, mispredict detection, predictor training and statistics
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolver_if.slave bus,
    output logic             empty,
    output logic             underflow_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Each entry is {pred_taken, pred_fallthrough}
    logic [PC_W:0]   mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;

    logic            pop;
    logic            push;
    logic            mispredict;
    logic [PC_W:0]   head;

    logic            upd_branch_q;
    logic            upd_taken_q;
    logic            flush_q;
    logic [PC_W-1:0] redirect_pc_q;

    assign empty          = (count == '0);
    assign bus.pred_ready = (count != FULL_COUNT);
    assign head           = mem[rd_ptr];
    assign pop            = bus.resolve_valid && !empty;
    assign mispredict     = pop && (head[PC_W] != bus.resolve_taken);
    // A push in a mispredict cycle belongs to the wrong path and is discarded
    assign push           = bus.pred_valid && bus.pred_ready && !mispredict;

    assign bus.upd_branch  = upd_branch_q;
    assign bus.upd_taken   = upd_taken_q;
    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redirect_pc_q;

    // Queue storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.pred_taken, bus.pred_fallthrough};
        end
    end

    // Queue pointers and occupancy; a mispredict drops every younger entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Registered training strobe, flush pulse and redirect target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_branch_q  <= 1'b0;
            upd_taken_q   <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            upd_branch_q <= pop;
            upd_taken_q  <= pop && bus.resolve_taken;
            flush_q      <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= bus.resolve_taken ? bus.resolve_target : head[PC_W-1:0];
            end
        end
    end

    // Saturating statistics and sticky underflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
            underflow_err    <= 1'b0;
        end else begin
            if (pop && branch_count != CNT_MAX) begin
                branch_count <= branch_count + 1'b1;
            end
            if (mispredict && mispredict_count != CNT_MAX) begin
                mispredict_count <= mispredict_count + 1'b1;
            end
            if (bus.resolve_valid && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver with directed vectors
module tb_branch_resolver;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       empty;
    logic       underflow_err;
    logic [3:0] branch_count;
    logic [3:0] mispredict_count;

    int n_total = 0;
    int n_pass  = 0;
    bit mon_en  = 1'b1;

    // Expected training event: {upd_taken, flush, redirect_pc}
    typedef struct packed {
        logic        taken;
        logic        flush;
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];

    branch_resolver_if #(.PC_W(32)) bus ();

    branch_resolver #(.DEPTH(4), .PC_W(32), .CNT_W(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus.slave),
        .empty            (empty),
        .underflow_err    (underflow_err),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic taken, input logic [31:0] ft);
        bus.pred_valid = 1'b1;
        bus.pred_taken = taken;
        bus.pred_fallthrough = ft;
        tick();
        bus.pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] tgt,
                           input logic e_flush, input logic [31:0] e_pc);
        exp_t e;
        e.taken = taken;
        e.flush = e_flush;
        e.pc    = e_pc;
        sb.push_back(e);
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = taken;
        bus.resolve_target = tgt;
        tick();
        bus.resolve_valid = 1'b0;
    endtask

    // Monitor: every upd_branch pulse must match the oldest expectation
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (bus.flush && !bus.upd_branch) begin
                chk("flush_without_upd", 32'(bus.flush), 32'd0);
            end
            if (bus.upd_branch) begin
                if (sb.size() == 0) begin
                    chk("unexpected_upd_branch", 32'(bus.upd_branch), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("upd_taken", 32'(bus.upd_taken), 32'(e.taken));
                    chk("flush", 32'(bus.flush), 32'(e.flush));
                    if (e.flush) chk("redirect_pc", bus.redirect_pc, e.pc);
                end
            end
        end
    end

    initial begin
        bus.pred_valid = 1'b0;
        bus.pred_taken = 1'b0;
        bus.pred_fallthrough = '0;
        bus.resolve_valid = 1'b0;
        bus.resolve_taken = 1'b0;
        bus.resolve_target = '0;
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(bus.pred_ready), 32'd1);
        chk("rst_upd_branch", 32'(bus.upd_branch), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_redirect", bus.redirect_pc, 32'd0);
        chk("rst_underflow", 32'(underflow_err), 32'd0);
        chk("rst_bcount", 32'(branch_count), 32'd0);
        chk("rst_mcount", 32'(mispredict_count), 32'd0);
        reset = 1'b0;
        tick();

        // Three correct taken predictions
        push(1'b1, 32'h104);
        push(1'b1, 32'h204);
        push(1'b1, 32'h304);
        chk("t1_not_empty", 32'(empty), 32'd0);
        resolve(1'b1, 32'h500, 1'b0, 32'd0);
        resolve(1'b1, 32'h600, 1'b0, 32'd0);
        resolve(1'b1, 32'h700, 1'b0, 32'd0);
        tick();
        chk("t1_bcount", 32'(branch_count), 32'd3);
        chk("t1_mcount", 32'(mispredict_count), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);

        // Predicted not-taken, actually taken: redirect to target
        push(1'b0, 32'h1004);
        resolve(1'b1, 32'h2000, 1'b1, 32'h2000);
        tick();
        chk("t2_bcount", 32'(branch_count), 32'd4);
        chk("t2_mcount", 32'(mispredict_count), 32'd1);
        chk("t2_redirect_hold", bus.redirect_pc, 32'h2000);

        // Predicted taken, actually not taken: redirect to fallthrough
        push(1'b1, 32'h40);
        resolve(1'b0, 32'h999, 1'b1, 32'h40);
        tick();
        chk("t3_bcount", 32'(branch_count), 32'd5);
        chk("t3_mcount", 32'(mispredict_count), 32'd2);

        // Fill to DEPTH, drop a fifth push, overlap push/pop at count 2
        push(1'b0, 32'h10);
        push(1'b0, 32'h20);
        push(1'b0, 32'h30);
        push(1'b0, 32'h40);
        chk("t4_full_ready", 32'(bus.pred_ready), 32'd0);
        push(1'b1, 32'hdead);
        chk("t4_still_full", 32'(bus.pred_ready), 32'd0);
        resolve(1'b0, 32'h0, 1'b0, 32'd0);
        resolve(1'b0, 32'h0, 1'b0, 32'd0);
        bus.pred_valid = 1'b1;
        bus.pred_taken = 1'b0;
        bus.pred_fallthrough = 32'h50;
        resolve(1'b0, 32'h0, 1'b0, 32'd0);
        bus.pred_valid = 1'b0;
        chk("t4_ready_cnt2", 32'(bus.pred_ready), 32'd1);
        resolve(1'b0, 32'h0, 1'b0, 32'd0);
        chk("t4_not_empty", 32'(empty), 32'd0);
        resolve(1'b0, 32'h0, 1'b0, 32'd0);
        chk("t4_empty", 32'(empty), 32'd1);
        tick();
        chk("t4_bcount", 32'(branch_count), 32'd10);

        // Mispredict with a same-cycle push: queue cleared, push lost
        push(1'b1, 32'h1100);
        push(1'b1, 32'h1200);
        push(1'b1, 32'h1300);
        bus.pred_valid = 1'b1;
        bus.pred_taken = 1'b1;
        bus.pred_fallthrough = 32'h1400;
        resolve(1'b0, 32'h0, 1'b1, 32'h1100);
        bus.pred_valid = 1'b0;
        chk("t5_empty", 32'(empty), 32'd1);
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        tick();
        bus.resolve_valid = 1'b0;
        tick();
        chk("t5_underflow", 32'(underflow_err), 32'd1);
        chk("t5_bcount", 32'(branch_count), 32'd11);
        chk("t5_mcount", 32'(mispredict_count), 32'd3);

        // Async reset with two entries queued and a mispredict pending
        push(1'b1, 32'h60);
        push(1'b1, 32'h70);
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b0;
        tick();
        #1;
        reset = 1'b1;
        bus.resolve_valid = 1'b0;
        #1;
        chk("r_empty", 32'(empty), 32'd1);
        chk("r_flush", 32'(bus.flush), 32'd0);
        chk("r_upd", 32'(bus.upd_branch), 32'd0);
        chk("r_redirect", bus.redirect_pc, 32'd0);
        chk("r_underflow", 32'(underflow_err), 32'd0);
        chk("r_bcount", 32'(branch_count), 32'd0);
        chk("r_mcount", 32'(mispredict_count), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Saturation of the 4-bit branch counter
        for (int i = 0; i < 20; i++) begin
            push(1'b1, 32'(i * 4));
            resolve(1'b1, 32'h0, 1'b0, 32'd0);
        end
        tick();
        chk("sat_bcount", 32'(branch_count), 32'd15);
        chk("sat_mcount", 32'(mispredict_count), 32'd0);
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Other end of the two-bit branch predictor interface. Fetch pushes each prediction in program order; execute resolves branches in the same order.
- The block compares each actual outcome against the queued prediction.
- It returns a one-cycle training strobe (branch/taken) to the predictor.
- On a wrong prediction it raises flush plus a redirect PC and squashes all younger in-flight predictions.
- It keeps saturating branch and mispredict statistics.

Parameters:
- DEPTH, 4, number of in-flight predictions queued. Power of two, at least 2.
- PC_W, 32, width of PC and target fields.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- pred_valid  input  1  fetch pushes a prediction this cycle
- pred_taken  input  1  predictor's predict_taken for this branch
- pred_fallthrough  input  PC_W  PC+4 of the branch
- pred_ready  output  1  queue can accept a push (not full)
- resolve_valid  input  1  execute resolves the oldest branch this cycle
- resolve_taken  input  1  actual branch outcome
- resolve_target  input  PC_W  computed taken target
- upd_branch  output  1  training strobe to predictor `branch`
- upd_taken  output  1  training outcome to predictor `taken`
- flush  output  1  mispredict: squash younger pipeline work
- redirect_pc  output  PC_W  correct fetch PC, valid while flush=1
- empty  output  1  no predictions in flight
- underflow_err  output  1  sticky: resolve arrived while queue empty
- branch_count  output  CNT_W  resolved branches, saturating
- mispredict_count  output  CNT_W  mispredictions, saturating

Behaviour:
- Reset (async, any cycle, including mid-flush):
  - Queue cleared: count=0, read and write pointers 0.
  - All registered outputs go to 0: upd_branch, upd_taken, flush, redirect_pc, underflow_err, both counters.
  - empty=1, pred_ready=1.
- Queue: circular FIFO of {pred_taken, pred_fallthrough}.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - pred_ready = (count != DEPTH), combinational. empty = (count == 0), combinational.
- Push: accepted when pred_valid && pred_ready && no mispredict pop in the same cycle.
  - pred_valid while full: push silently dropped. Fetch must hold or stall on pred_ready.
- Pop: resolve_valid && !empty pops the head.
  - mispredict = (head.pred_taken != resolve_taken), combinational on the pop cycle.
- Correct prediction, cycle N+1 (N = pop cycle):
  - upd_branch=1 and upd_taken=resolve_taken, for one cycle.
  - flush=0.
  - branch_count +1.
  - A simultaneous push and pop leaves count unchanged.
- Mispredict, cycle N+1:
  - upd_branch=1, upd_taken=resolve_taken.
  - flush=1 for exactly one cycle.
  - redirect_pc = resolve_taken ? resolve_target : head.pred_fallthrough.
  - branch_count +1, mispredict_count +1.
- Queue on mispredict, at edge N:
  - Entire queue cleared (count=0, rd_ptr=wr_ptr), because all younger entries are wrong-path.
  - A push in cycle N is discarded.
- Registered-output latency: all of upd_*, flush, redirect_pc, counters lag the event by one cycle. redirect_pc holds its last value when flush=0.
- Resolve while empty:
  - No pop, no upd_branch, counters unchanged.
  - underflow_err set, and stays set until reset.
- Counters saturate at 2^CNT_W-1 and do not wrap. mispredict_count never exceeds branch_count.
- No internal FSM beyond the FIFO. The flush output is a single-cycle pulse, never asserted on consecutive cycles unless two mispredicting resolves occur back-to-back. The second such resolve requires a new push after the clear.

Test Plan:
- Reset, then push 3 predictions (taken=1, fallthrough 0x104/0x204/0x304), then resolve 3 with taken=1 → upd_branch pulses 3 times with upd_taken=1, flush never asserts, branch_count=3, mispredict_count=0, empty=1.
- Push pred_taken=0 with fallthrough 0x1004, then resolve taken=1 with target 0x2000 → next cycle flush=1, redirect_pc=0x2000, upd_taken=1, mispredict_count=1.
- Push pred_taken=1 with fallthrough 0x40, then resolve taken=0 → redirect_pc=0x40.
- Push 4 entries with DEPTH=4 → pred_ready=0. A 5th pred_valid is dropped. Resolve 4 correct → exactly 4 upd_branch pulses. A simultaneous push and pop when count=2 keeps count=2.
- Fill 3 entries, mispredict the head while pred_valid=1 in the same cycle → queue empty afterwards (empty=1), the pushed entry is lost, and the next resolve sets underflow_err=1 with no upd_branch.
- Assert reset mid-stream with count=2 and flush pending → all outputs 0 immediately, empty=1. With CNT_W=4, run 20 correct resolves → branch_count saturates at 15.
